reg_file_rr_arbiter: RTL and testbench
======================================

Name: reg_file_rr_arbiter

Overview:
- Shares one single-port, read-first register file (128x32, write enable = ce && en, registered read of the addressed word) between two requesters, A and B.
- Round-robin arbitration, one access per cycle.
- Built-in clear sequencer that sweeps zeros into every location on command.
- Sits between the register file and two client blocks; the register file's wclk and rclk are both tied to this block's clk.

Parameters:
DATA_WIDTH, 32, word width
ADDR_WIDTH, 7, address width
MEM_CAPACITY, 128, number of words; must be <= 2**ADDR_WIDTH

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
clr_start  in  1  pulse: begin clear sweep
clr_busy  out  1  high while sweep in progress
a_req  in  1  requester A access request
a_we  in  1  A: 1=write, 0=read
a_addr  in  ADDR_WIDTH  A address
a_wdata  in  DATA_WIDTH  A write data
a_gnt  out  1  A granted this cycle (combinational)
a_rvalid  out  1  A read data valid
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  same as A, for requester B
rdata  out  DATA_WIDTH  read data, shared; qualified by a_rvalid/b_rvalid
mem_ce  out  1  register-file chip enable
mem_en  out  1  register-file write enable
mem_address  out  ADDR_WIDTH  register-file address
mem_wdata  out  DATA_WIDTH  register-file write data
mem_rdata  in  DATA_WIDTH  register-file registered read data

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Outputs while reset is high: clr_busy=0, a_rvalid=b_rvalid=0, gnt outputs 0, mem_ce=mem_en=0, round-robin pointer = A, FSM = RUN.
- FSM states:
  - RUN: normal arbitration.
  - CLEAR: sweep in progress.
- RUN -> CLEAR on clr_start=1. The clear counter loads 0 and clr_busy rises the next cycle.
- CLEAR behaviour, each cycle: mem_ce=1, mem_en=1, mem_address=counter, mem_wdata=0, all gnt=0. The counter increments by 1.
- CLEAR -> RUN after the write to MEM_CAPACITY-1. clr_busy falls the cycle after that write. The sweep takes exactly MEM_CAPACITY cycles.
- clr_start during CLEAR is ignored (no restart).
- Arbitration in RUN (combinational within the cycle):
  - Only one requester high: that requester is granted.
  - Both high: the requester selected by the pointer is granted.
  - Pointer update on a grant: moves to the non-granted requester. Unchanged when there is no grant.
- A grant drives the memory port in the same cycle:
  - mem_address = granted addr, mem_wdata = granted wdata.
  - mem_ce = 1, mem_en = granted we.
  - For a read, mem_en=0; mem_ce=1 is harmless.
- Requester handshake: a requester holds req/we/addr/wdata stable until it sees gnt. A request is consumed in the cycle gnt=1. The requester may present a new request in the next cycle.
- Read latency:
  - A read granted in cycle N gives x_rvalid=1 in cycle N+1, with rdata=mem_rdata (pass-through).
  - rvalid is a registered copy of (gnt && !we).
  - Back-to-back reads from alternating requesters give alternating rvalid each cycle.
- Read-first: a write granted in cycle N to address X, followed by a read of X granted in cycle N+1, returns the new data in N+2.
- rdata contents when no rvalid is high are don't-care.
- Simultaneous reset and clr_start: reset wins.
- reset during CLEAR: FSM returns to RUN and clr_busy=0; memory contents are partially cleared and are not defined by this block.
- clr_start in the same cycle as requests: the requests are granted that cycle, and CLEAR starts next cycle.
- Address handling: addresses >= MEM_CAPACITY are passed through unchanged; range checking is the caller's responsibility.

Decomposition:
- Shared package reg_file_pkg: DATA_WIDTH/ADDR_WIDTH/MEM_CAPACITY defaults and FSM state encoding (ST_RUN, ST_CLEAR).
- One natural sub-module: rr_arbiter_2 (request vector, pointer register, grant vector), reusable elsewhere.
- Register file instantiated only in the testbench, not inside this block.

Test Plan:
- Reset, then a_req write of 0xDEADBEEF to address 5, then a_req read of address 5 -> a_gnt high on each request cycle; a_rvalid=1 with rdata=0xDEADBEEF one cycle after the read grant.
- a_req and b_req both held high for 4 cycles, with reads of addresses 1 and 2 -> grants alternate A, B, A, B; rvalid alternates in the following cycles with the correct data.
- Only b_req high for 3 cycles -> b_gnt every cycle; pointer ends at A; a subsequent simultaneous request grants A first.
- Fill addresses 0..127 with nonzero data, pulse clr_start -> clr_busy high for exactly 128 cycles; no gnt during the sweep; reads of 0, 64 and 127 afterwards return 0.
- Pulse clr_start, assert reset at sweep cycle 40 -> clr_busy=0 the next cycle; FSM back in RUN; a_req granted immediately.
- Write 0x1 to address 9 (cycle N), read address 9 (cycle N+1), second clr_start during the sweep -> read returns 0x1; sweep length remains 128 cycles.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared parameters and FSM encoding for the register-file front end.
// Also names the requester slots used by the arbiter and the top level.
package reg_file_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 7;
  localparam int MEM_CAPACITY = 128;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a combinational grant.
// The pointer names the requester that wins the next tie.
module rr_arbiter_2
  import reg_file_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      if (i_req == 2'b11) o_gnt[r_ptr] = 1'b1;
      else                o_gnt = i_req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'(REQ_A);
    end else if (o_gnt[REQ_A]) begin
      r_ptr <= 1'(REQ_B);
    end else if (o_gnt[REQ_B]) begin
      r_ptr <= 1'(REQ_A);
    end
  end

endmodule

// File: rtl/reg_file_rr_arbiter.sv
// Shares one single-port register file between requesters A and B,
// with a clear sequencer that sweeps zeros through every word.
module reg_file_rr_arbiter #(
  parameter int DATA_WIDTH   = reg_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = reg_file_pkg::ADDR_WIDTH,
  parameter int MEM_CAPACITY = reg_file_pkg::MEM_CAPACITY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_ce,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import reg_file_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_CAPACITY - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;

  logic                  w_clearing;
  logic                  w_run_en;
  logic [1:0]            w_gnt;

  // Reset masks the combinational outputs in the same cycle it is asserted.
  assign w_clearing = (r_state == ST_CLEAR) && !reset;
  assign w_run_en   = (r_state == ST_RUN)   && !reset;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_run_en),
    .i_req ({b_req, a_req}),
    .o_gnt (w_gnt)
  );

  assign a_gnt    = w_gnt[REQ_A];
  assign b_gnt    = w_gnt[REQ_B];
  assign clr_busy = w_clearing;
  assign a_rvalid = r_a_rvalid && !reset;
  assign b_rvalid = r_b_rvalid && !reset;
  assign rdata    = mem_rdata;

  always_comb begin
    mem_ce      = 1'b0;
    mem_en      = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    if (w_clearing) begin
      mem_ce      = 1'b1;
      mem_en      = 1'b1;
      mem_address = r_clr_cnt;
    end else if (w_gnt[REQ_A]) begin
      mem_ce      = 1'b1;
      mem_en      = a_we;
      mem_address = a_addr;
      mem_wdata   = a_wdata;
    end else if (w_gnt[REQ_B]) begin
      mem_ce      = 1'b1;
      mem_en      = b_we;
      mem_address = b_addr;
      mem_wdata   = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_clr_cnt  <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_gnt[REQ_A] && !a_we;
      r_b_rvalid <= w_gnt[REQ_B] && !b_we;
      unique case (r_state)
        ST_RUN: begin
          if (clr_start) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          // clr_start is deliberately ignored here: a sweep never restarts.
          r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
          if (r_clr_cnt == LAST_ADDR) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_rr_arbiter.sv
// Directed bench: 128x32 read-first register file model behind the arbiter,
// hand-computed expectations checked on the falling edge.
module tb_reg_file_rr_arbiter;

  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr_start;
  logic          clr_busy;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [DW-1:0] rdata;
  logic          mem_ce, mem_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [128];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_rr_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .rdata       (rdata),
    .mem_ce      (mem_ce),
    .mem_en      (mem_en),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Read-first single-port register file: the read sees the pre-write word.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_en) mem[mem_address] <= mem_wdata;
      mem_rdata <= mem[mem_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_req = req; a_we = we; a_addr = addr; a_wdata = data;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    b_req = req; b_we = we; b_addr = addr; b_wdata = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cycles;
    int  bad;
    bit  done;

    // Reset held together with clr_start and a request: reset wins.
    reset = 1'b1; clr_start = 1'b1;
    set_a(1'b1, 1'b1, 7'd3, 32'h1);
    set_b(1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    check("rst_a_gnt", a_gnt, 0);
    check("rst_mem_ce", mem_ce, 0);
    check("rst_busy", clr_busy, 0);
    @(negedge clk);
    reset = 1'b0; clr_start = 1'b0; set_a(1'b0, 1'b0, '0, '0); #1;
    check("rst_vs_clr_busy", clr_busy, 0);
    check("rst_a_rvalid", a_rvalid, 0);

    // A writes then reads address 5.
    @(negedge clk); set_a(1'b1, 1'b1, 7'd5, 32'hDEADBEEF); #1;
    check("wr5_gnt", a_gnt, 1);
    check("wr5_mem_en", mem_en, 1);
    check("wr5_addr", mem_address, 5);
    check("wr5_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk); set_a(1'b1, 1'b0, 7'd5, '0); #1;
    check("rd5_gnt", a_gnt, 1);
    check("rd5_mem_en", mem_en, 0);
    check("rd5_mem_ce", mem_ce, 1);
    @(negedge clk); set_a(1'b0, 1'b0, '0, '0); #1;
    check("rd5_rvalid", a_rvalid, 1);
    check("rd5_rdata", rdata, 32'hDEADBEEF);
    check("rd5_b_rvalid", b_rvalid, 0);

    // B alone for three cycles; pointer ends at A.
    @(negedge clk); set_b(1'b1, 1'b1, 7'd1, 32'h11111111); #1;
    check("b_only_gnt0", b_gnt, 1);
    @(negedge clk); set_b(1'b1, 1'b1, 7'd2, 32'h22222222); #1;
    check("b_only_gnt1", b_gnt, 1);
    @(negedge clk); set_b(1'b1, 1'b0, 7'd2, '0); #1;
    check("b_only_gnt2", b_gnt, 1);
    check("b_only_a_gnt", a_gnt, 0);

    // Both reading: grants A,B,A,B; rvalid follows one cycle later.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        set_a(1'b1, 1'b0, 7'd1, '0);
        set_b(1'b1, 1'b0, 7'd2, '0);
      end else begin
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
      end
      #1;
      if (k < 4) begin
        check($sformatf("alt_a_gnt%0d", k), a_gnt, (k % 2 == 0));
        check($sformatf("alt_b_gnt%0d", k), b_gnt, (k % 2 == 1));
      end
      // k==0 follows B's solo read of address 2; afterwards A at odd k, B at even k.
      check($sformatf("alt_a_rvalid%0d", k), a_rvalid, (k % 2 == 1));
      check($sformatf("alt_b_rvalid%0d", k), b_rvalid, (k % 2 == 0));
      check($sformatf("alt_rdata%0d", k), rdata, (k % 2 == 1) ? 32'h11111111 : 32'h22222222);
    end

    // Read-first: write 9 then read 9 on consecutive cycles returns new data.
    @(negedge clk); set_a(1'b1, 1'b1, 7'd9, 32'h1); #1;
    check("rf_wr_gnt", a_gnt, 1);
    @(negedge clk); set_a(1'b1, 1'b0, 7'd9, '0); #1;
    check("rf_rd_gnt", a_gnt, 1);
    @(negedge clk); set_a(1'b0, 1'b0, '0, '0); #1;
    check("rf_rdata", rdata, 32'h1);

    // Fill every word with nonzero data, then confirm one of them.
    for (int i = 0; i < 128; i++) begin
      @(negedge clk); set_a(1'b1, 1'b1, AW'(i), 32'hA5000000 | i);
    end
    @(negedge clk); set_a(1'b1, 1'b0, 7'd64, '0);
    @(negedge clk); set_a(1'b0, 1'b0, '0, '0); #1;
    check("fill_rd64", rdata, 32'hA5000040);

    // Clear sweep with A requesting throughout and a second clr_start mid-sweep.
    @(negedge clk); clr_start = 1'b1; #1;
    check("clr_busy_not_yet", clr_busy, 0);
    cycles = 0; bad = 0; done = 1'b0;
    for (int g = 0; g < 300 && !done; g++) begin
      @(negedge clk);
      clr_start = (cycles == 60);
      set_a(1'b1, 1'b0, 7'd0, '0);
      #1;
      if (!clr_busy) begin
        done = 1'b1;
      end else begin
        if (a_gnt || b_gnt) bad++;
        if (!mem_ce || !mem_en) bad++;
        if (mem_address != AW'(cycles)) bad++;
        if (mem_wdata != '0) bad++;
        cycles++;
      end
    end
    check("sweep_len", cycles, 128);
    check("sweep_bad_cycles", bad, 0);
    check("post_sweep_gnt", a_gnt, 1);
    @(negedge clk); set_a(1'b1, 1'b0, 7'd64, '0); #1;
    check("clr_rd0_rvalid", a_rvalid, 1);
    check("clr_rd0", rdata, 0);
    @(negedge clk); set_a(1'b1, 1'b0, 7'd127, '0); #1;
    check("clr_rd64", rdata, 0);
    @(negedge clk); set_a(1'b0, 1'b0, '0, '0); #1;
    check("clr_rd127", rdata, 0);

    // clr_start together with a write: the write is granted, then reset at sweep cycle 40.
    @(negedge clk); clr_start = 1'b1; set_a(1'b1, 1'b1, 7'd100, 32'h77); #1;
    check("clr_start_with_req_gnt", a_gnt, 1);
    for (int c = 1; c < 40; c++) begin
      @(negedge clk); clr_start = 1'b0; set_a(1'b0, 1'b0, '0, '0);
    end
    #1;
    check("sweep39_busy", clr_busy, 1);
    @(negedge clk); reset = 1'b1; #1;
    check("rst_in_sweep_busy", clr_busy, 0);
    check("rst_in_sweep_ce", mem_ce, 0);
    @(negedge clk); reset = 1'b0; set_a(1'b1, 1'b0, 7'd100, '0); #1;
    check("after_rst_busy", clr_busy, 0);
    check("after_rst_gnt", a_gnt, 1);
    @(negedge clk); set_a(1'b0, 1'b0, '0, '0); #1;
    check("after_rst_rvalid", a_rvalid, 1);
    check("after_rst_rdata", rdata, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
